moldudp64_req_gen: RTL and testbench

- Transmit-side companion of the MoldUDP64 missed-message detector.
- Takes the sequence-gap reports the detector raises and queues them.
- Builds MoldUDP64 retransmission request packets: session 10 B, sequence number 8 B, message count 2 B, all big-endian.
- Serializes each packet as a 3-beat, 64-bit valid/ready stream to the UDP transmit path.
- Gaps larger than one request can carry are split into several consecutive requests.

---
 rtl/moldudp64_req_gen.sv | 187 ++++++++++++++++++
 tb/tb_moldudp64_req_gen.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_req_gen.sv
// MoldUDP64 retransmission request generator: queues gap reports from the
// missed-message detector and streams each as a 3-beat 64-bit request packet.
module moldudp64_req_gen #(
  parameter int unsigned SEQ_NUM_W   = 18,
  parameter int unsigned SID_W       = 80,
  parameter int unsigned ML_W        = 16,
  parameter int unsigned MAX_REQ_CNT = 32'h0000_FFFF,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 miss_v_i,
  input  logic [SID_W-1:0]     miss_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
  output logic                 req_v_o,
  input  logic                 req_ready_i,
  output logic [63:0]          req_data_o,
  output logic [7:0]           req_keep_o,
  output logic                 req_last_o,
  output logic                 busy_o,
  output logic                 ovf_o
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = SID_W + 2 * SEQ_NUM_W;
  localparam int unsigned CHK_W = SEQ_NUM_W + 1;
  localparam int unsigned CMP_W = ((SEQ_NUM_W > 32) ? SEQ_NUM_W : 32) + 1;

  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_B2} state_t;

  state_t               r_state, w_state_n;
  logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count, w_count_n;
  logic [SID_W-1:0]     r_sid, w_sid_n;
  logic [SEQ_NUM_W-1:0] r_start, w_start_n, r_rem, w_rem_n;
  logic                 r_req_v, r_req_last, r_busy, r_ovf;
  logic [7:0]           r_req_keep;
  logic [63:0]          r_req_data;
  logic                 w_req_v_n, w_req_last_n, w_busy_n;
  logic [7:0]           w_req_keep_n;
  logic [63:0]          w_req_data_n;
  logic                 w_empty, w_full, w_push_req, w_push, w_drop, w_pop, w_hs;
  logic [ENT_W-1:0]     w_head;
  logic [CHK_W-1:0]     w_chunk, w_chunk_n;
  logic [ML_W-1:0]      w_cnt_ml;
  logic [63:0]          w_seq64_n;

  // Messages carried by one request: the remainder, capped at MAX_REQ_CNT.
  function automatic logic [CHK_W-1:0] chunk_of(input logic [SEQ_NUM_W-1:0] rem);
    if (CMP_W'(rem) > CMP_W'(MAX_REQ_CNT)) return CHK_W'(MAX_REQ_CNT);
    return CHK_W'(rem);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_req = miss_v_i && (miss_cnt_i != '0);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_count_n  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_hs       = r_req_v && req_ready_i;
  assign w_chunk    = chunk_of(r_rem);

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // Next state, FIFO pop and working-register updates
  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_sid_n   = r_sid;
    w_start_n = r_start;
    w_rem_n   = r_rem;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop     = 1'b1;
        w_sid_n   = w_head[ENT_W-1 -: SID_W];
        w_start_n = w_head[2*SEQ_NUM_W-1 -: SEQ_NUM_W];
        w_rem_n   = w_head[SEQ_NUM_W-1:0];
        w_state_n = S_B0;
      end
      S_B0: if (w_hs) w_state_n = S_B1;
      S_B1: if (w_hs) w_state_n = S_B2;
      S_B2: if (w_hs) begin
        w_rem_n   = r_rem - SEQ_NUM_W'(w_chunk);
        w_start_n = r_start + SEQ_NUM_W'(w_chunk);
        if (w_rem_n != '0) begin
          w_state_n = S_B0;
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_sid_n   = w_head[ENT_W-1 -: SID_W];
          w_start_n = w_head[2*SEQ_NUM_W-1 -: SEQ_NUM_W];
          w_rem_n   = w_head[SEQ_NUM_W-1:0];
          w_state_n = S_B0;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_chunk_n = chunk_of(w_rem_n);
  assign w_cnt_ml  = ML_W'(w_chunk_n);
  assign w_seq64_n = 64'(w_start_n);

  // Next beat contents, registered below so outputs hold during stalls
  always_comb begin
    w_req_v_n    = 1'b0;
    w_req_last_n = 1'b0;
    w_req_keep_n = 8'h00;
    w_req_data_n = 64'h0;
    w_busy_n     = (w_count_n != '0) || (w_state_n != S_IDLE);
    case (w_state_n)
      S_B0: begin
        w_req_v_n    = 1'b1;
        w_req_keep_n = 8'hFF;
        for (int i = 0; i < 8; i++) w_req_data_n[8*i +: 8] = w_sid_n[SID_W-1-8*i -: 8];
      end
      S_B1: begin
        w_req_v_n           = 1'b1;
        w_req_keep_n        = 8'hFF;
        w_req_data_n[7:0]   = w_sid_n[15:8];
        w_req_data_n[15:8]  = w_sid_n[7:0];
        for (int i = 0; i < 6; i++) w_req_data_n[8*(i+2) +: 8] = w_seq64_n[63-8*i -: 8];
      end
      S_B2: begin
        w_req_v_n           = 1'b1;
        w_req_last_n        = 1'b1;
        w_req_keep_n        = 8'h0F;
        w_req_data_n[7:0]   = w_seq64_n[15:8];
        w_req_data_n[15:8]  = w_seq64_n[7:0];
        w_req_data_n[23:16] = w_cnt_ml[ML_W-1 -: 8];
        w_req_data_n[31:24] = w_cnt_ml[7:0];
      end
      default: ;
    endcase
  end

  // Gap FIFO storage; contents need no reset since the pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {miss_sid_i, miss_start_i, miss_cnt_i};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_sid      <= '0;
      r_start    <= '0;
      r_rem      <= '0;
      r_req_v    <= 1'b0;
      r_req_last <= 1'b0;
      r_req_keep <= 8'h00;
      r_req_data <= 64'h0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_n;
      r_sid      <= w_sid_n;
      r_start    <= w_start_n;
      r_rem      <= w_rem_n;
      r_req_v    <= w_req_v_n;
      r_req_last <= w_req_last_n;
      r_req_keep <= w_req_keep_n;
      r_req_data <= w_req_data_n;
      r_busy     <= w_busy_n;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign req_v_o    = r_req_v;
  assign req_last_o = r_req_last;
  assign req_keep_o = r_req_keep;
  assign req_data_o = r_req_data;
  assign busy_o     = r_busy;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_moldudp64_req_gen.sv
// Bench for moldudp64_req_gen: random reports and ready patterns checked
// against a byte-level packet model of the MoldUDP64 request format.
module tb_moldudp64_req_gen;
  localparam int unsigned SEQ_W  = 18;
  localparam int unsigned TB_MAX = 16;
  localparam int unsigned BUDGET = 2000;

  logic        clk;
  logic        nreset;
  logic        miss_v_i;
  logic [79:0] miss_sid_i;
  logic [17:0] miss_start_i;
  logic [17:0] miss_cnt_i;
  logic        req_v_o;
  logic        req_ready_i;
  logic [63:0] req_data_o;
  logic [7:0]  req_keep_o;
  logic        req_last_o;
  logic        busy_o;
  logic        ovf_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [72:0] exp_q[$];
  logic [72:0] got_q[$];

  moldudp64_req_gen #(
    .SEQ_NUM_W(SEQ_W), .SID_W(80), .ML_W(16), .MAX_REQ_CNT(TB_MAX), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .nreset(nreset),
    .miss_v_i(miss_v_i), .miss_sid_i(miss_sid_i),
    .miss_start_i(miss_start_i), .miss_cnt_i(miss_cnt_i),
    .req_v_o(req_v_o), .req_ready_i(req_ready_i),
    .req_data_o(req_data_o), .req_keep_o(req_keep_o), .req_last_o(req_last_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Model: serialize one request as the 24-byte wire image, 8 bytes per beat
  task automatic push_packet(input logic [79:0] sid, input logic [17:0] seq, input int unsigned cnt);
    logic [7:0]  pkt [24];
    logic [63:0] seq64;
    logic [15:0] c16;
    logic [63:0] d;
    seq64 = 64'(seq);
    c16   = 16'(cnt);
    for (int k = 0; k < 24; k++) pkt[k] = 8'h00;
    for (int k = 0; k < 10; k++) pkt[k] = sid[79-8*k -: 8];
    for (int k = 0; k < 8; k++)  pkt[10+k] = seq64[63-8*k -: 8];
    pkt[18] = c16[15:8];
    pkt[19] = c16[7:0];
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = pkt[8*b+i];
      exp_q.push_back({(b == 2), ((b == 2) ? 8'h0F : 8'hFF), d});
    end
  endtask

  task automatic model_report(input logic [79:0] sid, input logic [17:0] start, input logic [17:0] cnt);
    int unsigned s, rem, c;
    s   = start;
    rem = cnt;
    while (rem != 0) begin
      c = (rem > TB_MAX) ? TB_MAX : rem;
      push_packet(sid, 18'(s), c);
      rem -= c;
      s = (s + c) % (1 << SEQ_W);
    end
  endtask

  function automatic logic [79:0] rand_sid();
    return 80'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_report(input logic [79:0] sid, input logic [17:0] start, input logic [17:0] cnt);
    miss_v_i     = 1'b1;
    miss_sid_i   = sid;
    miss_start_i = start;
    miss_cnt_i   = cnt;
    step(1);
    miss_v_i     = 1'b0;
  endtask

  // Collect accepted beats; also counts stalled beats that changed
  task automatic capture(input int n, input int pct, output int cycles, output int stall_err);
    logic        have_prev;
    logic [72:0] prev;
    logic        rdy;
    cycles    = 0;
    stall_err = 0;
    have_prev = 1'b0;
    prev      = '0;
    got_q.delete();
    while (got_q.size() < n && cycles < BUDGET) begin
      if (have_prev && (req_v_o !== 1'b1 || {req_last_o, req_keep_o, req_data_o} !== prev))
        stall_err++;
      rdy         = ($urandom_range(99) < pct);
      req_ready_i = rdy;
      have_prev   = req_v_o && !rdy;
      prev        = {req_last_o, req_keep_o, req_data_o};
      if (req_v_o === 1'b1 && rdy) got_q.push_back({req_last_o, req_keep_o, req_data_o});
      step(1);
      cycles++;
    end
    req_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    step(2);
    n_tests++;
    if ({req_v_o, req_last_o, req_keep_o, req_data_o, busy_o, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got v=%b last=%b keep=%h data=%h busy=%b ovf=%b exp all zero",
               req_v_o, req_last_o, req_keep_o, req_data_o, busy_o, ovf_o);
    end
    nreset = 1'b1;
    step(2);
    n_tests++;
    if (req_v_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got v=%b busy=%b exp 0 0", req_v_o, busy_o);
    end
  endtask

  task automatic test_single();
    int cyc, serr;
    exp_q.delete();
    model_report(80'd5, 18'd100, 18'd3);
    send_report(80'd5, 18'd100, 18'd3);
    n_tests++;
    if (req_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat1 got v=%b exp 0", req_v_o);
    end
    step(1);
    n_tests++;
    if (req_v_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lat2 got v=%b exp 1", req_v_o);
    end
    capture(3, 100, cyc, serr);
    n_tests++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL single_cycles got %0d exp 3", cyc);
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL single_nbeats got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (busy_o !== 1'b0 || req_v_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle got busy=%b v=%b exp 0 0", busy_o, req_v_o);
    end
  endtask

  task automatic test_cnt_zero();
    int bad;
    bad = 0;
    send_report(rand_sid(), 18'd77, 18'd0);
    for (int i = 0; i < 5; i++) begin
      if (req_v_o !== 1'b0 || busy_o !== 1'b0 || ovf_o !== 1'b0) bad++;
      step(1);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL cnt_zero got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_split();
    int cyc, serr;
    logic [79:0] sid;
    sid = rand_sid();
    exp_q.delete();
    model_report(sid, 18'd10, 18'd40);
    send_report(sid, 18'd10, 18'd40);
    step(1);
    capture(9, 100, cyc, serr);
    n_tests++;
    if (cyc !== 9) begin
      n_fail++;
      $display("FAIL split_cycles got %0d exp 9", cyc);
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL split_nbeats got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL split_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL split_busy_fall got %b exp 0", busy_o);
    end
  endtask

  task automatic test_wrap();
    int cyc, serr;
    logic [79:0] sid;
    sid = rand_sid();
    exp_q.delete();
    model_report(sid, 18'd262142, 18'd20);
    send_report(sid, 18'd262142, 18'd20);
    capture(6, 100, cyc, serr);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_nbeats got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, serr;
    exp_q.delete();
    model_report(80'd5, 18'd100, 18'd3);
    send_report(80'd5, 18'd100, 18'd3);
    capture(3, 40, cyc, serr);
    n_tests++;
    if (serr !== 0) begin
      n_fail++;
      $display("FAIL bp_stable got %0d unstable stalls exp 0", serr);
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_nbeats got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int cyc, serr;
    logic [79:0] sid;
    logic [17:0] st, ct;
    for (int r = 0; r < 4; r++) begin
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
        sid = rand_sid();
        st  = 18'($urandom());
        ct  = 18'($urandom_range(40, 1));
        model_report(sid, st, ct);
        send_report(sid, st, ct);
      end
      capture(exp_q.size(), 60, cyc, serr);
      n_tests++;
      if (serr !== 0 || got_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_stream got stalls=%0d beats=%0d exp stalls=0 beats=%0d",
                 r, serr, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d got %h exp %h", r, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int cyc, serr, bad;
    logic [79:0] sid;
    logic [17:0] st, ct;
    exp_q.delete();
    req_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sid = rand_sid();
      st  = 18'($urandom());
      ct  = 18'($urandom_range(16, 1));
      if (k < 5) model_report(sid, st, ct);
      if (k == 5) begin
        n_tests++;
        if (ovf_o !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early got %b exp 0", ovf_o);
        end
      end
      send_report(sid, st, ct);
    end
    n_tests++;
    if (ovf_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set got ovf=%b busy=%b exp 1 1", ovf_o, busy_o);
    end
    capture(15, 100, cyc, serr);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ovf_nbeats got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
    bad = 0;
    req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (req_v_o !== 1'b0) bad++;
      step(1);
    end
    req_ready_i = 1'b0;
    n_tests++;
    if (bad !== 0 || ovf_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_tail got extra=%0d ovf=%b exp 0 1", bad, ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, serr;
    logic [79:0] sid;
    logic [17:0] st;
    send_report(rand_sid(), 18'($urandom()), 18'd5);
    step(1);
    req_ready_i = 1'b1;
    step(1);
    req_ready_i = 1'b0;
    n_tests++;
    if (req_v_o !== 1'b1 || req_last_o !== 1'b0 || req_keep_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL rstmid_in_b1 got v=%b last=%b keep=%h exp 1 0 ff", req_v_o, req_last_o, req_keep_o);
    end
    nreset = 1'b0;
    #1;
    n_tests++;
    if ({req_v_o, req_last_o, req_keep_o, req_data_o, busy_o, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear got v=%b last=%b keep=%h data=%h busy=%b ovf=%b exp all zero",
               req_v_o, req_last_o, req_keep_o, req_data_o, busy_o, ovf_o);
    end
    step(1);
    nreset = 1'b1;
    req_ready_i = 1'b1;
    step(3);
    req_ready_i = 1'b0;
    n_tests++;
    if (req_v_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_resume got v=%b busy=%b exp 0 0", req_v_o, busy_o);
    end
    sid = rand_sid();
    st  = 18'($urandom());
    exp_q.delete();
    model_report(sid, st, 18'd7);
    send_report(sid, st, 18'd7);
    step(1);
    capture(3, 100, cyc, serr);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_nbeats got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    nreset       = 1'b0;
    miss_v_i     = 1'b0;
    miss_sid_i   = '0;
    miss_start_i = '0;
    miss_cnt_i   = '0;
    req_ready_i  = 1'b0;
    #1;
    test_reset();
    test_single();
    test_cnt_zero();
    test_split();
    test_wrap();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
